// File: rtl/dpram_be_clr.sv
// Dual-port RAM with per-byte write enables and a built-in clear engine.
// The clear engine refills every word with clear_val_g after reset or on request.
// Both ports are blocked while it runs. The read path has optional output
// registers and a selectable read-during-write behaviour.
//
// state | meaning
// CLEAR | engine writes clear_val_g to one word per cycle; ports blocked, busy=1
// READY | normal dual-port operation; clear=1 starts a new fill from address 0
module dpram_be_clr #(
  parameter int                      data_width_g = 8,
  parameter int                      addr_width_g = 14,
  parameter int                      rdw_new_g    = 0,
  parameter int                      out_reg_g    = 0,
  parameter logic [data_width_g-1:0] clear_val_g  = '0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      clear,
  output logic                      busy,
  output logic                      collision,
  input  logic                      ram_cs_a,
  input  logic                      wren_a,
  input  logic [data_width_g/8-1:0] be_a,
  input  logic [addr_width_g-1:0]   address_a,
  input  logic [data_width_g-1:0]   data_a,
  output logic [data_width_g-1:0]   q_a,
  output logic                      q_valid_a,
  input  logic                      ram_cs_b,
  input  logic                      wren_b,
  input  logic [data_width_g/8-1:0] be_b,
  input  logic [addr_width_g-1:0]   address_b,
  input  logic [data_width_g-1:0]   data_b,
  output logic [data_width_g-1:0]   q_b,
  output logic                      q_valid_b
);

  localparam int depth_c = 2 ** addr_width_g;
  localparam int bytes_c = data_width_g / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                    state, state_nxt;
  logic [addr_width_g-1:0]   cnt, cnt_nxt;
  logic [data_width_g-1:0]   mem [depth_c];

  logic                      acc_a, acc_b, we_a, we_b, clr_we, coll_c;
  logic [data_width_g-1:0]   post_a, post_b;
  logic [data_width_g-1:0]   rd_word [2];
  logic [1:0]                acc;
  logic [data_width_g-1:0]   s1_q [2];
  logic [1:0]                s1_v;
  logic [data_width_g-1:0]   q_r [2];
  logic [1:0]                qv_r;

  // Clear engine state and fill counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Clear engine next state: stop after writing the last word, never wrap
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        if (cnt == '1) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      READY: begin
        if (clear) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy   = (state == CLEAR);
  // Memory is only written on a clock edge with reset released
  assign clr_we = busy & reset_n;
  assign acc_a  = ram_cs_a & ~busy;
  assign acc_b  = ram_cs_b & ~busy;
  assign we_a   = acc_a & wren_a;
  assign we_b   = acc_b & wren_b;
  assign coll_c = we_a & we_b & (address_a == address_b);
  assign acc    = {acc_b, acc_a};

  // Word each address will hold after this edge; port A bytes override port B
  always_comb begin
    post_a = mem[address_a];
    post_b = mem[address_b];
    for (int i = 0; i < bytes_c; i++) begin
      if (we_b && be_b[i] && (address_b == address_a)) post_a[i*8 +: 8] = data_b[i*8 +: 8];
      if (we_a && be_a[i])                               post_a[i*8 +: 8] = data_a[i*8 +: 8];
      if (we_b && be_b[i])                               post_b[i*8 +: 8] = data_b[i*8 +: 8];
      if (we_a && be_a[i] && (address_a == address_b)) post_b[i*8 +: 8] = data_a[i*8 +: 8];
    end
  end

  // Read-during-write on the own port selects new data only if configured;
  // a read of the other port's write target always sees the old word
  always_comb begin
    rd_word[0] = ((rdw_new_g != 0) && we_a) ? post_a : mem[address_a];
    rd_word[1] = ((rdw_new_g != 0) && we_b) ? post_b : mem[address_b];
  end

  // Memory array: clear fill, or byte-masked port writes (A written last so it wins)
  always_ff @(posedge clock) begin
    if (clr_we) mem[cnt] <= clear_val_g;
    for (int i = 0; i < bytes_c; i++) begin
      if (we_b && be_b[i]) mem[address_b][i*8 +: 8] <= data_b[i*8 +: 8];
      if (we_a && be_a[i]) mem[address_a][i*8 +: 8] <= data_a[i*8 +: 8];
    end
  end

  // Read pipeline, valid flags and collision pulse; reset discards in-flight reads
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      collision <= 1'b0;
      s1_v      <= '0;
      qv_r      <= '0;
      for (int p = 0; p < 2; p++) begin
        s1_q[p] <= '0;
        q_r[p]  <= '0;
      end
    end else begin
      collision <= coll_c;
      for (int p = 0; p < 2; p++) begin
        s1_v[p] <= acc[p];
        if (acc[p]) s1_q[p] <= rd_word[p];
        if (out_reg_g != 0) begin
          qv_r[p] <= s1_v[p];
          if (s1_v[p]) q_r[p] <= s1_q[p];
        end else begin
          qv_r[p] <= acc[p];
          if (acc[p]) q_r[p] <= rd_word[p];
        end
      end
    end
  end

  assign q_a       = q_r[0];
  assign q_b       = q_r[1];
  assign q_valid_a = qv_r[0];
  assign q_valid_b = qv_r[1];

endmodule

// File: tb/tb_dpram_be_clr.sv
// Scoreboard bench for dpram_be_clr. Two instances share the same stimulus:
// d0 uses the default configuration (old-data RDW, no output register), and
// d1 uses new-data RDW with the output register. A reference memory predicts
// every read result and its due cycle. A negedge monitor checks the results.
module tb_dpram_be_clr;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic cs_a = 1'b0, wren_a = 1'b0, cs_b = 1'b0, wren_b = 1'b0;
  logic [1:0] be_a = '0, be_b = '0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] data_a = '0, data_b = '0;

  logic busy0, busy1, coll0, coll1;
  logic [DW-1:0] q0a, q0b, q1a, q1b;
  logic qv0a, qv0b, qv1a, qv1b;

  logic [DW-1:0] mq [4];
  logic          mv [4];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_left = 16;
  logic exp_coll = 1'b0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_v [4][$];
  int            exp_due [4][$];
  logic [DW-1:0] last_exp [4];

  always #5 clock = ~clock;

  dpram_be_clr #(.data_width_g(DW), .addr_width_g(AW), .rdw_new_g(0), .out_reg_g(0),
                 .clear_val_g(16'h0000)) d0 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy0), .collision(coll0),
    .ram_cs_a(cs_a), .wren_a(wren_a), .be_a(be_a), .address_a(addr_a), .data_a(data_a),
    .q_a(q0a), .q_valid_a(qv0a),
    .ram_cs_b(cs_b), .wren_b(wren_b), .be_b(be_b), .address_b(addr_b), .data_b(data_b),
    .q_b(q0b), .q_valid_b(qv0b));

  dpram_be_clr #(.data_width_g(DW), .addr_width_g(AW), .rdw_new_g(1), .out_reg_g(1),
                 .clear_val_g(16'h0000)) d1 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy1), .collision(coll1),
    .ram_cs_a(cs_a), .wren_a(wren_a), .be_a(be_a), .address_a(addr_a), .data_a(data_a),
    .q_a(q1a), .q_valid_a(qv1a),
    .ram_cs_b(cs_b), .wren_b(wren_b), .be_b(be_b), .address_b(addr_b), .data_b(data_b),
    .q_b(q1b), .q_valid_b(qv1b));

  assign mq[0] = q0a;  assign mv[0] = qv0a;
  assign mq[1] = q0b;  assign mv[1] = qv0b;
  assign mq[2] = q1a;  assign mv[2] = qv1a;
  assign mq[3] = q1b;  assign mv[3] = qv1b;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endfunction

  // Reference model: one memory word array, busy as a remaining-cycles count
  always @(posedge clock or negedge reset_n) begin
    logic mb, aa, ab, wa, wb;
    logic [DW-1:0] old_a, old_b, new_a, new_b;
    if (!reset_n) begin
      busy_left = 16;
      exp_coll  = 1'b0;
      for (int p = 0; p < 4; p++) begin
        exp_v[p].delete();
        exp_due[p].delete();
      end
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      cyc++;
      mb = (busy_left != 0);
      aa = cs_a && !mb;
      ab = cs_b && !mb;
      wa = aa && wren_a;
      wb = ab && wren_b;
      old_a = ref_mem[addr_a];
      old_b = ref_mem[addr_b];
      for (int i = 0; i < 2; i++)
        if (wb && be_b[i]) ref_mem[addr_b][i*8 +: 8] = data_b[i*8 +: 8];
      for (int i = 0; i < 2; i++)
        if (wa && be_a[i]) ref_mem[addr_a][i*8 +: 8] = data_a[i*8 +: 8];
      new_a = ref_mem[addr_a];
      new_b = ref_mem[addr_b];
      if (aa) begin
        exp_v[0].push_back(old_a);               exp_due[0].push_back(cyc);
        exp_v[2].push_back(wa ? new_a : old_a);  exp_due[2].push_back(cyc + 1);
      end
      if (ab) begin
        exp_v[1].push_back(old_b);               exp_due[1].push_back(cyc);
        exp_v[3].push_back(wb ? new_b : old_b);  exp_due[3].push_back(cyc + 1);
      end
      exp_coll = wa && wb && (addr_a == addr_b);
      if (mb) busy_left--;
      else if (clear) begin
        busy_left = 16;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
    end
  end

  // Monitor: compare DUT outputs against the scoreboard away from the active edge
  always @(negedge clock) begin
    logic [DW-1:0] v;
    int d;
    if (!reset_n) begin
      chk("reset_busy0", busy0, 1);
      chk("reset_busy1", busy1, 1);
      chk("reset_coll0", coll0, 0);
      chk("reset_coll1", coll1, 0);
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("reset_q%0d", p), mq[p], 0);
        chk($sformatf("reset_qv%0d", p), mv[p], 0);
        last_exp[p] = '0;
      end
    end else begin
      chk("busy0", busy0, busy_left != 0);
      chk("busy1", busy1, busy_left != 0);
      chk("collision0", coll0, exp_coll);
      chk("collision1", coll1, exp_coll);
      for (int p = 0; p < 4; p++) begin
        if (mv[p]) begin
          if (exp_v[p].size() == 0) begin
            chk($sformatf("unexpected_valid%0d", p), mv[p], 0);
          end else begin
            v = exp_v[p].pop_front();
            d = exp_due[p].pop_front();
            chk($sformatf("q%0d", p), mq[p], v);
            chk($sformatf("latency%0d", p), cyc, d);
            last_exp[p] = v;
          end
        end else begin
          chk($sformatf("hold%0d", p), mq[p], last_exp[p]);
          if (exp_v[p].size() != 0 && exp_due[p][0] <= cyc) begin
            chk($sformatf("missing_valid%0d", p), mv[p], 1);
            void'(exp_v[p].pop_front());
            void'(exp_due[p].pop_front());
          end
        end
      end
    end
  end

  task automatic idle();
    cs_a = 0; cs_b = 0; wren_a = 0; wren_b = 0; clear = 0;
  endtask

  task automatic set_a(logic w, logic [1:0] be, logic [AW-1:0] ad, logic [DW-1:0] d);
    cs_a = 1; wren_a = w; be_a = be; addr_a = ad; data_a = d;
  endtask

  task automatic set_b(logic w, logic [1:0] be, logic [AW-1:0] ad, logic [DW-1:0] d);
    cs_b = 1; wren_b = w; be_b = be; addr_b = ad; data_b = d;
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic cycle();
    @(negedge clock);
    idle();
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      set_a(0, 2'b00, AW'(i), '0);
      set_b(0, 2'b00, AW'(DEPTH - 1 - i), '0);
      cycle();
    end
    repeat (3) cycle();
  endtask

  // Start right after a negedge: reset held through one rising edge
  task automatic pulse_reset();
    #2 reset_n = 0;
    @(negedge clock);
    #2 reset_n = 1;
  endtask

  task automatic hold_reads_while_busy(int n);
    for (int i = 0; i < n; i++) begin
      set_a(0, 2'b00, AW'($urandom_range(0, DEPTH - 1)), '0);
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    repeat (3) @(negedge clock);
    #2 reset_n = 1;
    // Initial clear: port A held selected, all offered reads must be dropped
    hold_reads_while_busy(16);
    read_all();

    // Byte-enable merge on address 3
    set_a(1, 2'b11, 4'd3, 16'h1234); cycle();
    set_a(1, 2'b10, 4'd3, 16'hABCD); cycle();
    set_a(0, 2'b00, 4'd3, '0);       cycle();
    repeat (3) cycle();

    // Read-during-write, same port and cross port
    set_a(1, 2'b11, 4'd5, 16'h1111); cycle();
    set_a(1, 2'b11, 4'd5, 16'h2222); set_b(0, 2'b00, 4'd5, '0); cycle();
    repeat (3) cycle();

    // Simultaneous writes to one address
    set_a(1, 2'b01, 4'd7, 16'hAAAA); set_b(1, 2'b11, 4'd7, 16'hBBBB); cycle();
    set_a(0, 2'b00, 4'd7, '0); cycle();
    repeat (3) cycle();

    // Pipelined read of a known word
    set_a(1, 2'b11, 4'd2, 16'h0F0F); cycle();
    set_b(0, 2'b00, 4'd2, '0); set_a(0, 2'b00, 4'd2, '0); cycle();
    repeat (4) cycle();

    // Reads accepted on the edge that starts a clear still complete
    clear = 1; set_a(0, 2'b00, 4'd3, '0); set_b(0, 2'b00, 4'd7, '0); cycle();
    hold_reads_while_busy(17);
    read_all();

    // Randomized traffic with occasional clears
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(0, 3) != 0)
        set_a(1'($urandom_range(0, 1)), 2'($urandom), AW'($urandom_range(0, 7)), 16'($urandom));
      if ($urandom_range(0, 3) != 0)
        set_b(1'($urandom_range(0, 1)), 2'($urandom), AW'($urandom_range(0, 7)), 16'($urandom));
      clear = ($urandom_range(0, 59) == 0);
      step();
    end
    idle();
    repeat (20) cycle();
    read_all();

    // Clear, ignored re-request, then reset mid-clear and a fresh full clear
    clear = 1; cycle();
    repeat (3) cycle();
    clear = 1; cycle();
    set_a(0, 2'b00, 4'd1, '0); step(); step();
    idle();
    pulse_reset();
    hold_reads_while_busy(16);
    read_all();

    // Reset with reads in flight discards them
    set_a(1, 2'b11, 4'd9, 16'h5A5A); cycle();
    set_a(0, 2'b00, 4'd9, '0); set_b(0, 2'b00, 4'd9, '0); step();
    idle();
    pulse_reset();
    hold_reads_while_busy(16);
    read_all();

    for (int t = 0; t < 10; t++) begin
      if (exp_v[0].size() + exp_v[1].size() + exp_v[2].size() + exp_v[3].size() == 0) break;
      cycle();
    end
    for (int p = 0; p < 4; p++) chk($sformatf("drain%0d", p), exp_v[p].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
